// File: rtl/shift_register_seq.sv
// Sequenced multi-mode shift register: each accepted command shifts or rotates
// the register by a programmable count, one position per clock, with start/busy/done handshaking.
module shift_register_seq #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [N-1:0]     data,
    input  logic             sin,
    output logic [N-1:0]     q_reg,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_SAR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       mode_reg, mode_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N-1:0]     q_next;
    logic             sout_next, busy_next, done_next;

    logic [2:0]       step_mode;
    logic             is_shift;
    logic [N-1:0]     shifted;
    logic             shifted_out;

    // The acceptance edge already applies the first position, so the shifter
    // follows the live mode in IDLE and the captured mode in SHIFT.
    assign step_mode = (state_reg == IDLE) ? mode : mode_reg;
    assign is_shift  = (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROL) ||
                       (mode == M_ROR) || (mode == M_SAR);

    always_comb begin
        shifted     = q_reg;
        shifted_out = sout;
        case (step_mode)
            M_SHL: begin shifted = {q_reg[N-2:0], sin};        shifted_out = q_reg[N-1]; end
            M_SHR: begin shifted = {sin, q_reg[N-1:1]};        shifted_out = q_reg[0];   end
            M_ROL: begin shifted = {q_reg[N-2:0], q_reg[N-1]}; shifted_out = q_reg[N-1]; end
            M_ROR: begin shifted = {q_reg[0], q_reg[N-1:1]};   shifted_out = q_reg[0];   end
            M_SAR: begin shifted = {q_reg[N-1], q_reg[N-1:1]}; shifted_out = q_reg[0];   end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            mode_reg  <= M_HOLD;
            cnt_reg   <= CNT_ZERO;
            q_reg     <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            sout      <= sout_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && is_shift && (amount > CNT_ONE)) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_ONE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        q_next    = q_reg;
        sout_next = sout;
        cnt_next  = cnt_reg;
        mode_next = mode_reg;
        done_next = 1'b0;
        if (state_reg == IDLE) begin
            if (start) begin
                mode_next = mode;
                if (is_shift && (amount != CNT_ZERO)) begin
                    q_next    = shifted;
                    sout_next = shifted_out;
                    cnt_next  = amount - CNT_ONE;
                    done_next = (amount == CNT_ONE);
                end else begin
                    done_next = 1'b1;
                    if (mode == M_LOAD)  q_next = data;
                    if (mode == M_CLEAR) q_next = '0;
                end
            end
        end else begin
            q_next    = shifted;
            sout_next = shifted_out;
            cnt_next  = cnt_reg - CNT_ONE;
            done_next = (cnt_reg == CNT_ONE);
        end
        busy_next = (state_next == SHIFT);
    end
endmodule

// File: tb/tb_shift_register_seq.sv
// Directed and randomised checks of shift_register_seq: reset, immediate ops,
// multi-cycle shifts/rotates, ignored starts, back-to-back and mid-shift reset.
module tb_shift_register_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [3:0] amount = 4'd0;
    logic [7:0] data = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q_reg;
    logic       sout, busy, done;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_q;
    logic       m_sout, m_busy, m_done;
    logic [2:0] m_mode;
    int         m_left;

    shift_register_seq #(.N(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
        .data(data), .sin(sin), .q_reg(q_reg), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Issues one command at a negedge and waits (bounded) for its done pulse.
    task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                           output int cyc, output int bcyc);
        mode = m; amount = a; data = d; start = 1'b1;
        cyc = 0; bcyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) bcyc++;
        end while (!done && cyc < 40);
        $display("cmd mode=%0d amount=%0d data=%h -> q=%h sout=%b cycles=%0d busy_cycles=%0d",
                 m, a, d, q_reg, sout, cyc, bcyc);
    endtask

    task automatic test_reset();
        int cyc, bcyc;
        reset = 1'b1; start = 1'b1; mode = 3'b011; data = 8'hFF;
        repeat (20) @(negedge clk);
        checks++; if (q_reg !== 8'h00) begin errors++; $display("FAIL reset_start_ignored: q=%h expected 00", q_reg); end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (q_reg !== 8'h00) begin errors++; $display("FAIL reset_q: q=%h expected 00", q_reg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: done=%b expected 0", done); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout: sout=%b expected 0", sout); end
        $display("txn reset released: q=%h busy=%b done=%b sout=%b", q_reg, busy, done, sout);
    endtask

    task automatic test_load_hold();
        int cyc, bcyc;
        run_cmd(3'b011, 4'd0, 8'h55, cyc, bcyc);
        checks++; if (q_reg !== 8'h55) begin errors++; $display("FAIL load_q: q=%h expected 55", q_reg); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL load_latency: cycles=%0d expected 1", cyc); end
        checks++; if (bcyc !== 0) begin errors++; $display("FAIL load_busy: busy_cycles=%0d expected 0", bcyc); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_single_done: done=%b expected 0", done); end
        run_cmd(3'b000, 4'd3, 8'hFF, cyc, bcyc);
        checks++; if (q_reg !== 8'h55) begin errors++; $display("FAIL hold_q: q=%h expected 55", q_reg); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL hold_latency: cycles=%0d expected 1", cyc); end
    endtask

    task automatic test_rol();
        int cyc, bcyc;
        logic [7:0] exp_q [3];
        exp_q = '{8'h03, 8'h06, 8'h0C};
        run_cmd(3'b011, 4'd0, 8'h81, cyc, bcyc);
        mode = 3'b100; amount = 4'd3; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++; if (q_reg !== exp_q[i]) begin errors++; $display("FAIL rol_step%0d_q: q=%h expected %h", i, q_reg, exp_q[i]); end
            checks++; if (busy !== (i < 2)) begin errors++; $display("FAIL rol_step%0d_busy: busy=%b expected %b", i, busy, (i < 2)); end
            checks++; if (done !== (i == 2)) begin errors++; $display("FAIL rol_step%0d_done: done=%b expected %b", i, done, (i == 2)); end
            if (i == 0) begin
                checks++; if (sout !== 1'b1) begin errors++; $display("FAIL rol_first_sout: sout=%b expected 1", sout); end
            end
        end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL rol_final_sout: sout=%b expected 0", sout); end
        $display("txn rol 3 on 81 -> q=%h sout=%b", q_reg, sout);
    endtask

    task automatic test_shift_modes();
        int cyc, bcyc;
        run_cmd(3'b011, 4'd0, 8'h80, cyc, bcyc);
        run_cmd(3'b110, 4'd2, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'hE0) begin errors++; $display("FAIL sar_q: q=%h expected e0", q_reg); end
        checks++; if (cyc !== 2 || bcyc !== 1) begin errors++; $display("FAIL sar_timing: cycles=%0d busy=%0d expected 2/1", cyc, bcyc); end
        run_cmd(3'b111, 4'd0, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'h00) begin errors++; $display("FAIL clear_q: q=%h expected 00", q_reg); end
        sin = 1'b1;
        run_cmd(3'b010, 4'd8, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'hFF) begin errors++; $display("FAIL shr8_q: q=%h expected ff", q_reg); end
        checks++; if (cyc !== 8 || bcyc !== 7) begin errors++; $display("FAIL shr8_timing: cycles=%0d busy=%0d expected 8/7", cyc, bcyc); end
        sin = 1'b0;
        run_cmd(3'b001, 4'd9, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'h00) begin errors++; $display("FAIL shl9_q: q=%h expected 00", q_reg); end
        checks++; if (cyc !== 9) begin errors++; $display("FAIL shl9_latency: cycles=%0d expected 9", cyc); end
        run_cmd(3'b011, 4'd0, 8'h01, cyc, bcyc);
        run_cmd(3'b101, 4'd1, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'h80 || sout !== 1'b1) begin errors++; $display("FAIL ror1: q=%h sout=%b expected 80/1", q_reg, sout); end
        checks++; if (cyc !== 1 || bcyc !== 0) begin errors++; $display("FAIL ror1_timing: cycles=%0d busy=%0d expected 1/0", cyc, bcyc); end
        run_cmd(3'b100, 4'd0, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'h80 || cyc !== 1) begin errors++; $display("FAIL rol0: q=%h cycles=%0d expected 80/1", q_reg, cyc); end
        run_cmd(3'b011, 4'd0, 8'h3C, cyc, bcyc);
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL load_keeps_sout: sout=%b expected 1", sout); end
        run_cmd(3'b100, 4'd10, 8'h00, cyc, bcyc);
        checks++; if (q_reg !== 8'hF0 || cyc !== 10) begin errors++; $display("FAIL rol10_wrap: q=%h cycles=%0d expected f0/10", q_reg, cyc); end
    endtask

    task automatic test_ignore_and_back_to_back();
        int cyc, bcyc;
        run_cmd(3'b011, 4'd0, 8'hF0, cyc, bcyc);
        mode = 3'b101; amount = 4'd5; start = 1'b1; cyc = 0;
        @(negedge clk); cyc++;
        mode = 3'b111; amount = 4'd0; data = 8'h11;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk); cyc++;
        end
        checks++; if (q_reg !== 8'h87) begin errors++; $display("FAIL ror5_ignore_q: q=%h expected 87", q_reg); end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL ror5_latency: cycles=%0d expected 5", cyc); end
        $display("txn ror 5 on f0 with ignored clear -> q=%h cycles=%0d", q_reg, cyc);
        mode = 3'b011; data = 8'hAA; start = 1'b1;
        @(negedge clk);
        checks++; if (q_reg !== 8'hAA || done !== 1'b1) begin errors++; $display("FAIL b2b_load: q=%h done=%b expected aa/1", q_reg, done); end
        mode = 3'b111;
        @(negedge clk);
        start = 1'b0;
        checks++; if (q_reg !== 8'h00 || done !== 1'b1) begin errors++; $display("FAIL b2b_clear: q=%h done=%b expected 00/1", q_reg, done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: done=%b expected 0", done); end
        $display("txn back-to-back load aa / clear -> q=%h", q_reg);
    endtask

    task automatic test_reset_mid_shift();
        int cyc, bcyc;
        run_cmd(3'b011, 4'd0, 8'h01, cyc, bcyc);
        sin = 1'b0; mode = 3'b001; amount = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (q_reg !== 8'h04 || busy !== 1'b1) begin errors++; $display("FAIL shl6_midway: q=%h busy=%b expected 04/1", q_reg, busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({q_reg, sout, busy, done} !== 11'd0) begin errors++; $display("FAIL mid_reset: q=%h sout=%b busy=%b done=%b expected all 0", q_reg, sout, busy, done); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || q_reg !== 8'h00) begin errors++; $display("FAIL after_mid_reset: q=%h busy=%b done=%b expected 00/0/0", q_reg, busy, done); end
        $display("txn reset during shl 6 -> q=%h busy=%b done=%b", q_reg, busy, done);
    endtask

    // Reference: a pending-position count drained one step per edge.
    task automatic model_edge();
        logic dn;
        dn = 1'b0;
        if (!m_busy && start) begin
            m_mode = mode;
            if (mode == 3'b011) m_q = data;
            if (mode == 3'b111) m_q = 8'h00;
            if (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) m_left = int'(amount);
            if (m_left == 0) dn = 1'b1;
        end
        if (m_left > 0) begin
            case (m_mode)
                3'd1: begin m_sout = m_q[7]; m_q = {m_q[6:0], sin};    end
                3'd2: begin m_sout = m_q[0]; m_q = {sin, m_q[7:1]};    end
                3'd4: begin m_sout = m_q[7]; m_q = {m_q[6:0], m_q[7]}; end
                3'd5: begin m_sout = m_q[0]; m_q = {m_q[0], m_q[7:1]}; end
                default: begin m_sout = m_q[0]; m_q = {m_q[7], m_q[7:1]}; end
            endcase
            m_left--;
            if (m_left == 0) dn = 1'b1;
        end
        m_busy = (m_left > 0);
        m_done = dn;
    endtask

    task automatic test_random();
        int accepted = 0;
        int cyc = 0;
        m_q = q_reg; m_sout = sout; m_busy = 1'b0; m_done = 1'b0; m_mode = 3'd0; m_left = 0;
        while (accepted < 100 && cyc < 5000) begin
            start  = ($urandom_range(0, 2) != 0);
            mode   = 3'($urandom_range(0, 7));
            amount = 4'($urandom_range(0, 10));
            data   = 8'($urandom);
            sin    = 1'($urandom_range(0, 1));
            if (!m_busy && start) begin
                accepted++;
                $display("rand cmd %0d mode=%0d amount=%0d data=%h", accepted, mode, amount, data);
            end
            model_edge();
            @(negedge clk);
            cyc++;
            checks++;
            if ({q_reg, sout, busy, done} !== {m_q, m_sout, m_busy, m_done}) begin
                errors++;
                $display("FAIL random_cycle%0d: q=%h sout=%b busy=%b done=%b expected q=%h sout=%b busy=%b done=%b",
                         cyc, q_reg, sout, busy, done, m_q, m_sout, m_busy, m_done);
            end
        end
        start = 1'b0;
        checks++; if (accepted < 100) begin errors++; $display("FAIL random_budget: accepted=%0d expected 100", accepted); end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_rol();
        test_shift_modes();
        test_ignore_and_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_register_seq.md
# shift_register_seq

Parametrised, multi-mode sequenced shift register; next generation of the single-step universal `shift_register`. Each accepted command shifts or rotates the register a programmable number of positions at one position per clock, with start/busy/done handshaking and a serial input and output. Used as a standalone ArchBench testcase and as a serialiser/deserialiser building block. Checked against its post-route netlist by the same compare-style bench.

## Interface
- `N`, 8: register width in bits, ≥ 2.
- `CNT_W`, $clog2(N)+1: width of `amount`, so a shift of N positions is expressible.

Ports, clock and reset first:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  in  1  command request; sampled only when `busy`=0.
- `mode`  in  3  command; captured at acceptance.
- `amount`  in  CNT_W  shift/rotate count; captured at acceptance.
- `data`  in  N  parallel load value.
- `sin`  in  1  serial fill bit for logical shifts; sampled live at every shift edge.
- `q_reg`  out  N  register contents.
- `sout`  out  1  last bit shifted or rotated out.
- `busy`  out  1  shifts still pending.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Mode encoding. mode[2]=0 keeps the legacy ctrl encoding:
  - 000 hold
  - 001 shl: fill `sin` at bit 0
  - 010 shr: fill `sin` at bit N-1
  - 011 load `data`
  - 100 rol
  - 101 ror
  - 110 sar: fill with the current bit N-1
  - 111 clear
- FSM has two states, IDLE and SHIFT.
- In IDLE, `start`=1 is accepted at the edge:
  - hold, load, clear, or any shift mode with `amount`=0: the operation completes at that edge (load or clear `q_reg`; otherwise no change). Stay in IDLE; `done`=1 for the next cycle.
  - shift or rotate with `amount`=A≥1: first position applied at the acceptance edge, remaining counter := A-1.
    - A=1: stay in IDLE, pulse `done`.
    - A>1: go to SHIFT with `busy`=1.
- In SHIFT:
  - One position is applied per edge and the counter decrements.
  - At the edge that applies the final position: return to IDLE, `busy`:=0, `done`:=1 for one cycle.
  - Total shifts applied equal A exactly.
- A > N is legal. Logical shifts saturate to fill content; rotates wrap modulo N. Cycle count is still A.
- `sout` updates at every shift/rotate edge:
  - left modes: old bit N-1
  - right modes: old bit 0
  - `sout` is unchanged by hold, load and clear.
- `start` while `busy`=1 is ignored and not queued.
- `mode`, `amount` and `data` changes during SHIFT have no effect.
- Reset (any state, including mid-SHIFT):
  - `q_reg`=0, `sout`=0, `busy`=0, `done`=0.
  - counter = 0, state = IDLE.
  - Reset wins over a simultaneous `start`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: `q_reg`=0, `sout`=0, `busy`=0, `done`=0.
- Latency from acceptance edge to `done`=1 is one edge for immediate commands and A edges for a shift of A.
- `busy` is high for A-1 cycles; it falls in the same cycle `done` rises.
- Back-to-back operation: `start` asserted during the `done` cycle is accepted (`busy`=0), giving one command per cycle for immediate ops.
- `done` never asserts for two consecutive cycles from a single command.
- `sin` for shift k is the value present at the k-th shift edge.

## Test plan
- Reset held 20 cycles, then released -> `q_reg`=0x00, `busy`=0, `done`=0, `sout`=0. Hold start=1 during reset -> no command executes.
- load 0x55 -> `q_reg`=0x55 after 1 edge, one `done` pulse, `busy` never high. Then hold -> 0x55 retained, `done` pulse.
- rol A=3 on 0x81 -> `q_reg` sequence 0x03, 0x06, 0x0C; `busy`=1 for 2 cycles; `done` on the third cycle; `sout`=0.
- sar A=2 on 0x80 -> 0xE0. Then shr A=8 with `sin`=1 from 0x00 -> 0xFF after 8 edges. Then shl A=9 with `sin`=0 -> 0x00 after 9 edges.
- Pulse `start` with clear during a ror A=5 on 0xF0 -> ignored; result 0x87 and `done` after 5 edges. Then issue back-to-back load 0xAA / clear in consecutive cycles -> 0xAA then 0x00.
- Assert reset at the 3rd edge of shl A=6 -> all outputs 0 next cycle with no `done` pulse. 100 random accepted commands with random A in 0..N+2 -> match the reference model every cycle, zero mismatches against the post-route netlist.
